// File: rtl/johnson_counter.sv
// Twisted-ring (Johnson) counter with decoded phase index, terminal-count strobe
// and illegal-pattern detection; illegal patterns are flushed to zero on the next edge.
module johnson_counter #(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] outBus,
    output logic [PW-1:0]    phase,
    output logic             tc,
    output logic             illegal
);

    localparam int NSTATES = 2 * WIDTH;
    localparam logic [WIDTH-1:0] TC_PAT = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
        $error("johnson_counter: WIDTH must be in 2..16");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             legal;
    logic [PW-1:0]    phase_idx;

    // Phases 0..WIDTH fill ones from the LSB; later phases clear ones from the LSB.
    function automatic logic [WIDTH-1:0] pattern_of(input int k);
        logic [WIDTH-1:0] pat;
        pat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (k <= WIDTH) begin
                pat[i] = (i < k);
            end else begin
                pat[i] = (i >= k - WIDTH);
            end
        end
        return pat;
    endfunction

    always_comb begin
        legal     = 1'b0;
        phase_idx = '0;
        for (int k = 0; k < NSTATES; k++) begin
            if (cnt_q == pattern_of(k)) begin
                legal     = 1'b1;
                phase_idx = PW'(k);
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        if (legal) begin
            cnt_d = {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign outBus  = cnt_q;
    assign phase   = phase_idx;
    assign tc      = (cnt_q == TC_PAT);
    assign illegal = ~legal;

endmodule

// File: tb/tb_johnson_counter.sv
// Self-checking bench for johnson_counter: WIDTH=4 and WIDTH=3 instances checked
// against an arithmetic phase-index model under directed and randomized stimulus.
module tb_johnson_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst3;
    logic [3:0] out4;
    logic [2:0] ph4;
    logic       tc4;
    logic       ill4;
    logic [2:0] out3;
    logic [2:0] ph3;
    logic       tc3;
    logic       ill3;

    int n_checks = 0;
    int n_fail   = 0;
    int p4       = 0;
    int p3       = 0;

    always #5 clk = ~clk;

    johnson_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .outBus(out4), .phase(ph4), .tc(tc4), .illegal(ill4)
    );

    johnson_counter #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst3), .outBus(out3), .phase(ph3), .tc(tc3), .illegal(ill3)
    );

    // Expected register pattern for sequence index p of a w-bit Johnson counter.
    function automatic int exp_pat(input int w, input int p);
        if (p <= w) return (1 << p) - 1;
        return ((1 << w) - 1) & ~((1 << (p - w)) - 1);
    endfunction

    function automatic bit is_legal4(input int v);
        for (int p = 0; p < 8; p++) if (exp_pat(4, p) == v) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one rising edge and update the model; sample at the following falling edge.
    task automatic step4();
        @(posedge clk);
        if (rst) p4 = 0; else p4 = (p4 + 1) % 8;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] e4;
        rst  = 1'b1;
        rst3 = 1'b1;
        #2;
        n_checks++;
        if ($isunknown({out4, ph4, tc4, ill4}) || out4 !== 4'b0000 || ph4 !== 3'd0 || tc4 !== 1'b0 || ill4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset4: got out=%b ph=%0d tc=%b ill=%b, want 0000/0/0/0", out4, ph4, tc4, ill4);
        end
        n_checks++;
        if ($isunknown({out3, ph3, tc3, ill3}) || out3 !== 3'b000 || ph3 !== 3'd0 || tc3 !== 1'b0 || ill3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset3: got out=%b ph=%0d tc=%b ill=%b, want 000/0/0/0", out3, ph3, tc3, ill3);
        end
        @(negedge clk);
        rst = 1'b0;
        p4  = 0;
        step4();
        e4 = 4'(exp_pat(4, p4));
        n_checks++;
        if (out4 !== 4'b0001 || out4 !== e4) begin
            n_fail++;
            $display("FAIL release: got out=%b, want 0001", out4);
        end
    endtask

    task automatic test_free_run(input int cycles);
        logic [3:0] prev;
        logic [3:0] e4;
        for (int c = 0; c < cycles; c++) begin
            prev = out4;
            step4();
            e4 = 4'(exp_pat(4, p4));
            n_checks++;
            if (out4 !== e4 || ph4 !== 3'(p4) || tc4 !== (p4 == 7) || ill4 !== 1'b0) begin
                n_fail++;
                $display("FAIL free_run c%0d: got out=%b ph=%0d tc=%b ill=%b, want %b/%0d/%b/0",
                         c, out4, ph4, tc4, ill4, e4, p4, (p4 == 7));
            end
            n_checks++;
            if ($countones(prev ^ out4) != 1) begin
                n_fail++;
                $display("FAIL one_bit c%0d: got %b -> %b, want exactly one toggle", c, prev, out4);
            end
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        logic [3:0] e4;
        while (p4 != 5 && guard < 16) begin
            step4();
            guard++;
        end
        n_checks++;
        if (out4 !== 4'b1110) begin
            n_fail++;
            $display("FAIL reach_1110: got out=%b, want 1110", out4);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out4 !== 4'b0000 || ph4 !== 3'd0 || tc4 !== 1'b0 || ill4 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got out=%b ph=%0d tc=%b ill=%b, want 0000/0/0/0", out4, ph4, tc4, ill4);
        end
        @(negedge clk);
        rst = 1'b0;
        p4  = 0;
        test_free_run(17);
        e4 = 4'(exp_pat(4, p4));
        n_checks++;
        if (out4 !== 4'b0001 || out4 !== e4) begin
            n_fail++;
            $display("FAIL restart_end: got out=%b, want 0001", out4);
        end
    endtask

    task automatic test_long_hold();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step4();
            n_checks++;
            if (out4 !== 4'b0000 || ph4 !== 3'd0 || tc4 !== 1'b0) begin
                n_fail++;
                $display("FAIL long_hold e%0d: got out=%b ph=%0d tc=%b, want 0000/0/0", c, out4, ph4, tc4);
            end
        end
        rst = 1'b0;
        p4  = 0;
        test_free_run(3);
    endtask

    task automatic test_illegal(input logic [3:0] pat);
        #2 force dut4.cnt_q = pat;
        #1;
        n_checks++;
        if (ill4 !== 1'b1 || ph4 !== 3'd0 || tc4 !== 1'b0 || out4 !== pat) begin
            n_fail++;
            $display("FAIL illegal_flag %b: got out=%b ill=%b ph=%0d tc=%b, want ill=1 ph=0 tc=0", pat, out4, ill4, ph4, tc4);
        end
        release dut4.cnt_q;
        @(posedge clk);
        p4 = 0;
        @(negedge clk);
        n_checks++;
        if (out4 !== 4'b0000 || ill4 !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_recover %b: got out=%b ill=%b, want 0000/0", pat, out4, ill4);
        end
        test_free_run(2);
    endtask

    task automatic test_random_illegal(input int n);
        logic [3:0] pat;
        for (int i = 0; i < n; i++) begin
            pat = 4'($urandom_range(0, 15));
            while (is_legal4(int'(pat))) pat = 4'($urandom_range(0, 15));
            test_illegal(pat);
            test_free_run($urandom_range(1, 9));
        end
    endtask

    task automatic test_random_resets(input int n);
        int hold;
        for (int i = 0; i < n; i++) begin
            test_free_run($urandom_range(1, 20));
            #($urandom_range(1, 4));
            rst = 1'b1;
            #1;
            n_checks++;
            if (out4 !== 4'b0000 || ph4 !== 3'd0 || tc4 !== 1'b0 || ill4 !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_reset i%0d: got out=%b ph=%0d tc=%b ill=%b, want 0000/0/0/0", i, out4, ph4, tc4, ill4);
            end
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) step4();
            rst = 1'b0;
            p4  = 0;
        end
        test_free_run(4);
    endtask

    task automatic test_width3();
        logic [2:0] e3;
        @(negedge clk);
        rst3 = 1'b0;
        p3   = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            p3 = (p3 + 1) % 6;
            @(negedge clk);
            e3 = 3'(exp_pat(3, p3));
            n_checks++;
            if (out3 !== e3 || ph3 !== 3'(p3) || tc3 !== (p3 == 5) || ill3 !== 1'b0) begin
                n_fail++;
                $display("FAIL width3 c%0d: got out=%b ph=%0d tc=%b ill=%b, want %b/%0d/%b/0",
                         c, out3, ph3, tc3, ill3, e3, p3, (p3 == 5));
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run(50);
        test_async_reset();
        test_long_hold();
        test_illegal(4'b0101);
        test_illegal(4'b1010);
        test_illegal(4'b0100);
        test_random_illegal(6);
        test_random_resets(10);
        test_width3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
